// File: rtl/rx_packet_buffer.sv
// Receive-side packet buffer: a first-word-fall-through circular FIFO that sits
// between the serial receiver and the router core.
// A transfer happens on a rising edge where valid && ready on either side.
// Neither ready output depends combinationally on the matching valid input.
module rx_packet_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 55
) (
    input  logic                       Clk_S,
    input  logic                       Rst_n,
    input  logic [WIDTH-1:0]           RX_Data,
    input  logic                       RX_Data_Valid,
    output logic                       RX_Ready,
    output logic [WIDTH-1:0]           Pkt_Data,
    output logic                       Pkt_Valid,
    input  logic                       Pkt_Ready,
    input  logic                       Flush,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_rx_ready;

    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_cnt_next;

    assign w_push     = RX_Data_Valid && r_rx_ready;
    assign w_pop      = Pkt_Valid && Pkt_Ready;
    assign w_cnt_next = r_cnt + CW'(w_push) - CW'(w_pop);

    // Ready is registered from the next occupancy, so it falls on the very
    // edge that fills the buffer and a push into a full buffer cannot happen.
    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_rx_ready <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (Flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_rx_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= RX_Data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_cnt      <= w_cnt_next;
            r_rx_ready <= (w_cnt_next != CW'(DEPTH));
        end
    end

    assign RX_Ready  = r_rx_ready;
    assign Pkt_Valid = (r_cnt != '0);
    assign Pkt_Data  = r_mem[r_rd_ptr];
    assign Count     = r_cnt;

endmodule
